dmem_sized: RTL and testbench

DMEM_SIZED -- requirements
Module: dmem_sized

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_load_ext.sv | 40 ++++
 rtl/dmem_sized.sv | 215 +++++++++++++++++++++
 tb/tb_dmem_sized.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory dmem_sized:
// access-size encodings, FSM states and the per-size byte count.
package dmem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of bytes touched by an access; 0 marks an illegal size code.
    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        logic [2:0] n;
        case (size)
            SZ_B, SZ_BU: n = 3'd1;
            SZ_H, SZ_HU: n = 3'd2;
            SZ_W:        n = 3'd4;
            default:     n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane selection and sign/zero extension for dmem_sized.
// Takes the 32-bit word containing the access and the byte lane of the
// (already aligned) access; purely combinational.
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/halfword and extend it according to the size code.
    always_comb begin
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (size)
            SZ_B:    rdata = {{24{byte_s[7]}}, byte_s};
            SZ_BU:   rdata = {24'h000000, byte_s};
            SZ_H:    rdata = {{16{half_s[15]}}, half_s};
            SZ_HU:   rdata = {16'h0000, half_s};
            SZ_W:    rdata = word;
            default: rdata = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: byte-addressed little-endian data memory with B/H/W accesses,
// a fixed accept-to-response latency and a valid/ready request port.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned H/HU/W accesses
// are rejected with resp_err instead of being aligned down.
module dmem_sized
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int DWIDTH    = 32,
    parameter int LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [DWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DWIDTH-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         AW       = $clog2(MEM_DEPTH);
    localparam logic [2:0] CNT_LAST = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

    // Contents start at zero once; reset never clears them.
    logic [7:0] mem_q [MEM_DEPTH] = '{default: 8'h00};

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              lat_we_q, lat_we_d;
    logic [2:0]        lat_size_q, lat_size_d;
    logic [DWIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DWIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DWIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic              accept_s;
    logic              go_resp_s;
    logic              eff_we_s;
    logic [2:0]        eff_size_s;
    logic [DWIDTH-1:0] eff_addr_s;
    logic [DWIDTH-1:0] eff_wdata_s;
    logic [2:0]        nbytes_s;
    logic [32:0]       end_addr_s;
    logic              mis_s;
    logic              err_s;
    logic [1:0]        lane_s;
    logic [3:0]        be_s;
    logic [31:0]       wrep_s;
    logic [AW-1:0]     lane_idx_s [4];
    logic [31:0]       rd_word_s;
    logic [31:0]       ld_data_s;

    assign accept_s = req_valid && ready_q && (state_q == ST_IDLE);

    // Next-state logic: FSM, wait counter and request latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_size_d  = lat_size_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    lat_we_d    = req_we;
                    lat_size_d  = req_size;
                    lat_addr_d  = req_addr;
                    lat_wdata_d = req_wdata;
                    cnt_d       = 3'd0;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        go_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);
        ready_d   = (state_d == ST_IDLE);
    end

    // Access decode: with LATENCY=1 the memory is touched on the accept edge
    // itself, so the live request is used; otherwise the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_we_s    = req_we;
            eff_size_s  = req_size;
            eff_addr_s  = req_addr;
            eff_wdata_s = req_wdata;
        end else begin
            eff_we_s    = lat_we_q;
            eff_size_s  = lat_size_q;
            eff_addr_s  = lat_addr_q;
            eff_wdata_s = lat_wdata_q;
        end
        nbytes_s   = size_bytes(eff_size_s);
        // Bounds use the unaligned address so a straddling access is rejected.
        end_addr_s = {1'b0, eff_addr_s} + {30'd0, nbytes_s} - 33'd1;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_s = ((nbytes_s == 3'd2) && eff_addr_s[0]) ||
                ((nbytes_s == 3'd4) && (eff_addr_s[1:0] != 2'b00));
`else
        mis_s = 1'b0;
`endif
        err_s = eff_addr_s[31] || (nbytes_s == 3'd0) || mis_s ||
                (end_addr_s >= 33'(MEM_DEPTH));
        // Halfwords/words are aligned down inside their word.
        case (nbytes_s)
            3'd1: begin
                lane_s = eff_addr_s[1:0];
                be_s   = 4'b0001 << eff_addr_s[1:0];
                wrep_s = {4{eff_wdata_s[7:0]}};
            end
            3'd2: begin
                lane_s = {eff_addr_s[1], 1'b0};
                be_s   = eff_addr_s[1] ? 4'b1100 : 4'b0011;
                wrep_s = {2{eff_wdata_s[15:0]}};
            end
            3'd4: begin
                lane_s = 2'b00;
                be_s   = 4'b1111;
                wrep_s = eff_wdata_s;
            end
            default: begin
                lane_s = 2'b00;
                be_s   = 4'b0000;
                wrep_s = 32'h00000000;
            end
        endcase
        for (int j = 0; j < 4; j++) begin
            lane_idx_s[j]         = {eff_addr_s[AW-1:2], 2'b00} | AW'(j);
            rd_word_s[8*j +: 8]   = mem_q[lane_idx_s[j]];
        end
    end

    dmem_load_ext u_load_ext (
        .size  (eff_size_s),
        .lane  (lane_s),
        .word  (rd_word_s),
        .rdata (ld_data_s)
    );

    // Response values computed for the edge that enters RESP.
    always_comb begin
        resp_valid_d = go_resp_s;
        resp_err_d   = go_resp_s && err_s;
        if (go_resp_s && !err_s && !eff_we_s) begin
            resp_rdata_d = ld_data_s;
        end else begin
            resp_rdata_d = '0;
        end
    end

    // FSM, counter, request latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            ready_q      <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_size_q   <= 3'd0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            lat_we_q     <= lat_we_d;
            lat_size_q   <= lat_size_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-lane store on the edge entering RESP; reset drops the write.
    always_ff @(posedge clk) begin
        if (!rst && go_resp_s && eff_we_s && !err_s) begin
            for (int j = 0; j < 4; j++) begin
                if (be_s[j]) begin
                    mem_q[lane_idx_s[j]] <= wrep_s[8*j +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Scoreboard bench for dmem_sized: the driver pushes the expected response
// of each accepted request, a monitor pops and compares on resp_valid.
module tb_dmem_sized;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    dmem_sized #(.MEM_DEPTH(DEPTH), .DWIDTH(32), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Monitor: pop and compare on each response, idle outputs must be zero.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (cyc >= 2) begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                    chk({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                    chk({e.name, "_latency"}, 32'(cyc + 1 - e.acc), 32'(LAT));
                end
            end else if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
                chk("idle_outputs_zero", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
            end
        end
    end

    // Present one request at a negedge and wait (bounded) until accepted.
    task automatic issue(input string nm, input logic we, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr, input bit expect_resp);
        int n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk({nm, "_accept_timeout"}, 32'd1, 32'd0);
            req_valid = 1'b0;
        end else begin
            if (expect_resp) sb_q.push_back('{erd, eerr, cyc + 1, nm});
            @(negedge clk);
            req_valid = 1'b0;
            req_wdata = 32'hA5A5A5A5;
            req_addr  = 32'h0000_0FFF;
        end
    endtask

    initial begin
        int last;
        int n_acc;
        int n;
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of WAIT drops the store.
        issue("st_dropped", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_midrst", {31'd0, req_ready}, 32'd1);
        issue("ld_w_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'h00000000, 1'b0, 1'b1);

        // Sizes and extension.
        issue("st_w_20",  1'b1, 3'b010, 32'h20, 32'h8081F0F1, 32'h0, 1'b0, 1'b1);
        issue("ld_b_20",  1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFFF1, 1'b0, 1'b1);
        issue("ld_bu_20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h000000F1, 1'b0, 1'b1);
        issue("ld_h_20",  1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFFF0F1, 1'b0, 1'b1);
        issue("ld_hu_20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h0000F0F1, 1'b0, 1'b1);
        issue("st_b_21",  1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b1);
        issue("ld_w_20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h8081AAF1, 1'b0, 1'b1);

        // Upper boundary and sign bit of the address.
        issue("ld_w_3fd", 1'b0, 3'b010, 32'h3FD, 32'h0, 32'h0, 1'b1, 1'b1);
        issue("st_h_3ff", 1'b1, 3'b001, 32'h3FF, 32'h00001234, 32'h0, 1'b1, 1'b1);
        issue("ld_b_3ff", 1'b0, 3'b000, 32'h3FF, 32'h0, 32'h0, 1'b0, 1'b1);
        issue("ld_w_neg", 1'b0, 3'b010, 32'h80000020, 32'h0, 32'h0, 1'b1, 1'b1);

        // Alignment handling and illegal size.
        issue("st_w_20b", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b1);
        issue("ld_h_22",  1'b0, 3'b001, 32'h22, 32'h0, 32'h00001122, 1'b0, 1'b1);
        issue("ld_h_23",  1'b0, 3'b001, 32'h23, 32'h0, TRAP ? 32'h0 : 32'h00001122, TRAP, 1'b1);
        issue("ld_w_21",  1'b0, 3'b010, 32'h21, 32'h0, TRAP ? 32'h0 : 32'h11223344, TRAP, 1'b1);
        issue("ld_sz011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1'b1);
        issue("st_h_25",  1'b1, 3'b001, 32'h25, 32'hFFFFBEEF, 32'h0, TRAP, 1'b1);
        issue("ld_w_24",  1'b0, 3'b010, 32'h24, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, 1'b0, 1'b1);
        issue("st_sz111", 1'b1, 3'b111, 32'h24, 32'h55555555, 32'h0, 1'b1, 1'b1);
        issue("ld_w_24b", 1'b0, 3'b010, 32'h24, 32'h0, TRAP ? 32'h0 : 32'h0000BEEF, 1'b0, 1'b1);

        // Continuous req_valid: one accept every LAT+1 cycles.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b100;
        req_addr  = 32'h3FF;
        last  = -1;
        n_acc = 0;
        for (int k = 0; k < 8 * (LAT + 1) && n_acc < 4; k++) begin
            if (req_ready === 1'b1) begin
                sb_q.push_back('{32'h0, 1'b0, cyc + 1, "stream"});
                if (last >= 0) chk("stream_spacing", 32'(cyc + 1 - last), 32'(LAT + 1));
                last = cyc + 1;
                n_acc++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("stream_accepts", 32'(n_acc), 32'd4);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
